// File: rtl/bus_master_arbiter_if.sv
// Bus-sharing handshake between bus_master_arbiter, the 68000 BR/BG/BGACK/AS pins and the secondary masters.
// The master modport is the arbiter's view; slave is the CPU/requester side.
interface bus_master_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0] REQ_IN;
    logic [NUM_REQ-1:0] DONE_IN;
    logic               BG_IN;
    logic               AS_IN;
    logic               BR;
    logic               BGACK;
    logic [NUM_REQ-1:0] GNT;
    logic               TIMEOUT;

    modport master (
        input  REQ_IN, DONE_IN, BG_IN, AS_IN,
        output BR, BGACK, GNT, TIMEOUT
    );

    modport slave (
        output REQ_IN, DONE_IN, BG_IN, AS_IN,
        input  BR, BGACK, GNT, TIMEOUT
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin 68000 BR/BG/BGACK arbiter sharing the local bus between the CPU and NUM_REQ secondary masters.
// Define BUS_ARB_TIMEOUT_EN to cap each tenure at MAX_HOLD cycles and pulse TIMEOUT when the cap ends it.
module bus_master_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                 CPUCLK_IN,
    input  logic                 RESET_IN,
    bus_master_arbiter_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("bus_master_arbiter: NUM_REQ must be 2..8");
        end
        if (MAX_HOLD < 2) begin : g_bad_max_hold
            $error("bus_master_arbiter: MAX_HOLD must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        OWN,
        RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic               br_q, br_d;
    logic               bgack_q, bgack_d;
    logic               timeout_q, timeout_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   winner;
    logic               owner_end;
    logic               hold_expired;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    logic [CNT_W-1:0] hold_q, hold_d;

    assign hold_expired = (hold_q == CNT_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    // First requester at or above the rr pointer, wrapping to 0.
    always_comb begin
        int unsigned      idx;
        logic             found;
        logic [IDX_W-1:0] sel;
        idx    = 0;
        found  = 1'b0;
        sel    = '0;
        winner = rr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (!found && bus.REQ_IN[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    assign owner_end = bus.DONE_IN[owner_q] || !bus.REQ_IN[owner_q];

    always_comb begin
        state_d   = state_q;
        br_d      = 1'b0;
        bgack_d   = 1'b0;
        gnt_d     = '0;
        timeout_d = 1'b0;
        rr_d      = rr_q;
        owner_d   = owner_q;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.REQ_IN) begin
                    state_d = REQUEST;
                    br_d    = 1'b1;
                end
            end
            REQUEST: begin
                if (!(|bus.REQ_IN)) begin
                    state_d = IDLE;
                end else if (bus.BG_IN && !bus.AS_IN) begin
                    state_d = OWN;
                    bgack_d = 1'b1;
                    gnt_d   = NUM_REQ'(1) << winner;
                    owner_d = winner;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    br_d = 1'b1;
                end
            end
            OWN: begin
                bgack_d = 1'b1;
                if (owner_end || hold_expired) begin
                    // A normal end on the expiry cycle takes precedence over the timeout report.
                    state_d   = RELEASE;
                    timeout_d = hold_expired && !owner_end;
                end else begin
                    gnt_d = gnt_q;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
                rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            state_q   <= IDLE;
            br_q      <= 1'b0;
            bgack_q   <= 1'b0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
            rr_q      <= '0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            bgack_q   <= bgack_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign bus.BR      = br_q;
    assign bus.BGACK   = bgack_q;
    assign bus.GNT     = gnt_q;
    assign bus.TIMEOUT = timeout_q;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter (NUM_REQ=2, MAX_HOLD=8); follows BUS_ARB_TIMEOUT_EN if defined.
module tb_bus_master_arbiter;
    localparam int MAX_HOLD = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rr = 0;

    bus_master_arbiter_if #(.NUM_REQ(2)) bus ();

    bus_master_arbiter #(
        .NUM_REQ (2),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .CPUCLK_IN(clk),
        .RESET_IN (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Observation vector: {BR, BGACK, GNT[1:0], TIMEOUT}
    function automatic logic [4:0] obs();
        return {bus.BR, bus.BGACK, bus.GNT, bus.TIMEOUT};
    endfunction

    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed BR,BGACK,GNT,TO=%b required %b", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requesting master at or after the pointer, wrapping.
    function automatic int pick(input logic [1:0] r, input int p);
        int idx;
        for (int i = 0; i < 2; i++) begin
            idx = (p + i) % 2;
            if (r[idx[0]]) return idx;
        end
        return -1;
    endfunction

    // One full tenure from IDLE; the owner ends it (DONE or REQ drop) on OWN cycle k.
    task automatic tenure(input string tag, input logic [1:0] r, input int bg_delay,
                          input int as_cycles, input int k, input bit by_done);
        int         w;
        logic [1:0] g;
        logic [1:0] noise;
        bit         exp_to;
        bus.REQ_IN = r;
        tick();
        chk({tag, " br_rise"}, obs(), 5'b10_00_0);
        repeat (bg_delay) begin
            tick();
            chk({tag, " wait_bg"}, obs(), 5'b10_00_0);
        end
        bus.BG_IN = 1'b1;
        bus.AS_IN = 1'b1;
        repeat (as_cycles) begin
            tick();
            chk({tag, " as_busy"}, obs(), 5'b10_00_0);
        end
        bus.AS_IN = 1'b0;
        w = pick(r, rr);
        g = 2'b01 << w;
        tick();
        chk({tag, " grant"}, obs(), {2'b01, g, 1'b0});
        bus.BG_IN = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            noise       = 2'($urandom);
            bus.DONE_IN = noise & ~g;
            bus.REQ_IN  = noise | g;
            if (t == k) begin
                if (by_done) bus.DONE_IN = bus.DONE_IN | g;
                else         bus.REQ_IN  = bus.REQ_IN & ~g;
            end
            tick();
            if (t == k || (TO_EN && t == MAX_HOLD)) begin
                exp_to = TO_EN && (t == MAX_HOLD) && (t != k);
                chk({tag, " release"}, obs(), {2'b01, 2'b00, exp_to});
                break;
            end
            chk({tag, " own"}, obs(), {2'b01, g, 1'b0});
        end
        bus.DONE_IN = 2'b00;
        bus.REQ_IN  = 2'($urandom);
        tick();
        chk({tag, " guard"}, obs(), 5'b00_00_0);
        rr = (w + 1) % 2;
    endtask

    task automatic withdraw(input string tag, input logic [1:0] r);
        bus.REQ_IN = r;
        tick();
        chk({tag, " br_rise"}, obs(), 5'b10_00_0);
        bus.REQ_IN = 2'b00;
        bus.BG_IN  = 1'b1;
        tick();
        chk({tag, " withdrawn"}, obs(), 5'b00_00_0);
        bus.BG_IN = 1'b0;
        tick();
        chk({tag, " idle"}, obs(), 5'b00_00_0);
    endtask

    initial begin
        bus.REQ_IN  = 2'b00;
        bus.DONE_IN = 2'b00;
        bus.BG_IN   = 1'b0;
        bus.AS_IN   = 1'b0;
        repeat (3) tick();
        chk("reset_state", obs(), 5'b00_00_0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", obs(), 5'b00_00_0);

        // Basic tenure: BG three cycles after REQ, closed by DONE.
        tenure("basic", 2'b01, 2, 0, 3, 1'b1);

        // Reset mid-tenure; pointer (now 1) must return to 0.
        bus.REQ_IN = 2'b11;
        tick();
        chk("midreset br", obs(), 5'b10_00_0);
        bus.BG_IN = 1'b1;
        tick();
        chk("midreset grant", obs(), {2'b01, 2'b01 << pick(2'b11, rr), 1'b0});
        bus.BG_IN = 1'b0;
        tick();
        chk("midreset own", obs(), {2'b01, 2'b01 << pick(2'b11, rr), 1'b0});
        rst        = 1'b1;
        bus.REQ_IN = 2'b00;
        tick();
        chk("midreset clear", obs(), 5'b00_00_0);
        rst = 1'b0;
        rr  = 0;
        tick();
        chk("midreset released", obs(), 5'b00_00_0);

        // Round-robin across three tenures with both masters requesting.
        tenure("rr_a", 2'b11, 0, 0, 2, 1'b1);
        tenure("rr_b", 2'b11, 1, 0, 1, 1'b1);
        tenure("rr_c", 2'b11, 0, 0, 4, 1'b1);

        // CPU still cycling (AS high) while granting.
        tenure("as_hold", 2'b10, 0, 4, 2, 1'b0);

        withdraw("withdraw", 2'b01);

        // Long hold without DONE, then DONE exactly on the expiry cycle.
        tenure("long_hold", 2'b01, 0, 0, 12, 1'b0);
        tenure("done_at_limit", 2'b10, 0, 0, MAX_HOLD, 1'b1);
        tenure("drop_at_limit", 2'b01, 1, 0, MAX_HOLD, 1'b0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                withdraw("rnd_withdraw", 2'($urandom_range(1, 3)));
            end else begin
                tenure("rnd", 2'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)), int'($urandom_range(1, 12)),
                       1'($urandom_range(0, 1)));
            end
        end

        bus.REQ_IN = 2'b00;
        tick();
        chk("final_idle", obs(), 5'b00_00_0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
